imem_fetch: RTL and testbench

- Instruction-fetch initiator that drives the word-addressed, synchronous-read instruction ROM.
- Generates the fetch address stream and captures ROM data one cycle later.
- Buffers fetched words in a small queue and hands {pc, inst} to decode over a valid/ready handshake.
- Handles stalls without losing words, and branch/jump redirects with in-flight kill.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_queue.sv | 43 ++++
 rtl/imem_fetch.sv | 88 ++++++++
 tb/tb_imem_fetch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch queue entry type and a saturating counter helper.
package cpu_pkg;
   localparam int IMEM_AW = 30;
   localparam int INST_W  = 32;
   localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;
   typedef struct packed {
      logic [IMEM_AW-1:0] pc;
      logic [INST_W-1:0]  inst;
   } fetch_entry_t;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two FIFO of fetch entries; flush wins over push/pop.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           din,
   output logic [$clog2(QDEPTH):0] count,
   output fetch_entry_t           head
);
   localparam int PW = $clog2(QDEPTH);
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]   count_q, count_d;
   fetch_entry_t  mem_q [QDEPTH];
   fetch_entry_t  mem_d [QDEPTH];
   always_comb begin
      mem_d = mem_q;
      if (push && !flush) mem_d[wr_q] = din;
      rd_d    = flush ? '0 : rd_q + PW'(pop);
      wr_d    = flush ? '0 : wr_q + PW'(push);
      count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '{pc: '0, inst: INST_NOP};
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end
   assign count = count_q;
   assign head  = mem_q[rd_q];
endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: instruction fetch controller feeding decode from a sync-read ROM.
// Define IMEM_FETCH_PERF_EN to add saturating stall/redirect/fetch counters.
module imem_fetch
   import cpu_pkg::*;
#(
   parameter logic [IMEM_AW-1:0] RESET_PC = 30'h0,
   parameter int                 QDEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [INST_W-1:0]  imem_inst,
   output logic               fetch_valid,
   input  logic               fetch_ready,
   output logic [IMEM_AW-1:0] fetch_pc,
   output logic [INST_W-1:0]  fetch_inst,
   input  logic               redirect_valid,
   input  logic [IMEM_AW-1:0] redirect_pc
`ifdef IMEM_FETCH_PERF_EN
   ,
   output logic [31:0]        perf_stall_cyc,
   output logic [31:0]        perf_redirects,
   output logic [31:0]        perf_fetched
`endif
);
   logic [IMEM_AW-1:0]      nxt_q, nxt_d, req_pc_q, req_pc_d;
   logic                    inflight_q, inflight_d;
   logic                    pop, push, space, issue;
   logic [$clog2(QDEPTH):0] count;
   fetch_entry_t            head;
   assign fetch_valid = count != '0;
   // An in-flight word already owns a queue slot, so issue only when it still fits.
   always_comb begin
      pop        = fetch_valid & fetch_ready;
      space      = (32'(count) + 32'(inflight_q) - 32'(pop)) < 32'(QDEPTH);
      issue      = redirect_valid | space;
      imem_addr  = (rst & redirect_valid) ? redirect_pc : nxt_q;
      nxt_d      = issue ? imem_addr + IMEM_AW'(1) : nxt_q;
      req_pc_d   = imem_addr;
      inflight_d = issue;
      push       = inflight_q & ~redirect_valid;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nxt_q      <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         nxt_q      <= nxt_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end
   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ('{pc: req_pc_q, inst: imem_inst}),
      .count (count),
      .head  (head)
   );
   assign fetch_pc   = head.pc;
   assign fetch_inst = head.inst;
`ifdef IMEM_FETCH_PERF_EN
   logic [31:0] stall_q, stall_d, redir_q, redir_d, fetched_q, fetched_d;
   always_comb begin
      stall_d   = sat_inc(stall_q, fetch_valid & ~fetch_ready);
      redir_d   = sat_inc(redir_q, redirect_valid);
      fetched_d = sat_inc(fetched_q, pop & ~redirect_valid);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q   <= '0;
         redir_q   <= '0;
         fetched_q <= '0;
      end else begin
         stall_q   <= stall_d;
         redir_q   <= redir_d;
         fetched_q <= fetched_d;
      end
   end
   assign perf_stall_cyc = stall_q;
   assign perf_redirects = redir_q;
   assign perf_fetched   = fetched_q;
`endif
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: random stimulus checked against a pc-stream scoreboard plus directed latency cases.
module tb_imem_fetch;
   import cpu_pkg::*;
   logic        clk = 0, rst = 0, fetch_ready = 0, redirect_valid = 0;
   logic [29:0] redirect_pc = '0;
   logic [29:0] imem_addr, fetch_pc, w_addr, w_pc;
   logic [31:0] imem_inst, fetch_inst, w_rom, w_inst;
   logic        fetch_valid, w_valid;
`ifdef IMEM_FETCH_PERF_EN
   logic [31:0] p_stall, p_redir, p_fetch, w_stall, w_redir, w_fetch;
`endif
   always #5 clk = ~clk;
   always @(posedge clk) begin
      imem_inst <= {2'b10, imem_addr};
      w_rom     <= {2'b10, w_addr};
   end
   imem_fetch dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
      .fetch_inst(fetch_inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IMEM_FETCH_PERF_EN
      , .perf_stall_cyc(p_stall), .perf_redirects(p_redir), .perf_fetched(p_fetch)
`endif
   );
   imem_fetch #(.RESET_PC(30'h3FFF_FFFE)) dut_w (
      .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_inst(w_rom),
      .fetch_valid(w_valid), .fetch_ready(fetch_ready), .fetch_pc(w_pc),
      .fetch_inst(w_inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IMEM_FETCH_PERF_EN
      , .perf_stall_cyc(w_stall), .perf_redirects(w_redir), .perf_fetched(w_fetch)
`endif
   );
   int          n_cmp = 0, n_bad = 0;
   int          since;
   logic [29:0] exp_pc, last_pc;
   logic        last_stall;
   int unsigned m_stall, m_redir, m_fetch;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask
   // Spec-level model: valid only from 2 cycles after release/redirect, pcs strictly sequential.
   task automatic mon();
      if (since < 1000) since++;
`ifdef IMEM_FETCH_PERF_EN
      chk("perf_stall", p_stall, 64'(m_stall));
      chk("perf_redir", p_redir, 64'(m_redir));
      chk("perf_fetch", p_fetch, 64'(m_fetch));
      m_stall += 32'(fetch_valid & ~fetch_ready);
      m_redir += 32'(redirect_valid);
      m_fetch += 32'(fetch_valid & fetch_ready & ~redirect_valid);
`endif
      chk("valid", 64'(fetch_valid), 64'(since >= 2));
      if (last_stall) chk("hold_pc", fetch_pc, last_pc);
      if (redirect_valid) chk("redir_addr", imem_addr, redirect_pc);
      if (fetch_valid && fetch_ready && !redirect_valid) begin
         chk("pop_pc", fetch_pc, exp_pc);
         chk("pop_inst", fetch_inst, {2'b10, exp_pc});
         exp_pc++;
      end
      if (redirect_valid) begin
         exp_pc = redirect_pc;
         since  = 0;
      end
      last_stall = fetch_valid & ~fetch_ready & ~redirect_valid;
      last_pc    = fetch_pc;
   endtask
   task automatic cyc(input logic r, input logic v, input logic [29:0] p);
      @(posedge clk);
      #1;
      fetch_ready    = r;
      redirect_valid = v;
      redirect_pc    = p;
      @(negedge clk);
      mon();
   endtask
   task automatic release_rst();
      @(posedge clk);
      #1;
      rst            = 1;
      fetch_ready    = 1;
      redirect_valid = 0;
      since          = -1;
      exp_pc         = 30'h0;
      last_stall     = 0;
      m_stall        = 0;
      m_redir        = 0;
      m_fetch        = 0;
      @(negedge clk);
      mon();
   endtask
   initial begin
      logic [29:0] t;
      repeat (3) @(posedge clk);
      release_rst();
      chk("addr_k0", imem_addr, 30'h0);
      for (int k = 1; k < 6; k++) begin
         cyc(1, 0, '0);
         chk("addr_seq", imem_addr, 64'(k));
         if (k >= 2) begin
            t = 30'h3FFF_FFFE + 30'(k - 2);
            chk("wrap_pc", w_pc, t);
            chk("wrap_inst", w_inst, {2'b10, t});
         end
         if (k == 2) begin
            chk("first_pc", fetch_pc, 30'h0);
            chk("first_inst", fetch_inst, 32'h8000_0000);
         end
      end
      for (int k = 6; k < 12; k++) begin
         cyc(0, 0, '0);
         chk("stall_addr", imem_addr, 30'h6);
         chk("stall_head", fetch_pc, 30'h4);
      end
      cyc(1, 0, '0);
      chk("resume_addr", imem_addr, 30'h6);
      repeat (5) cyc(1, 0, '0);
      cyc(1, 1, 30'h46);
      cyc(1, 0, '0);
      cyc(1, 0, '0);
      chk("redir_pc", fetch_pc, 30'h46);
      chk("redir_next_addr", imem_addr, 30'h48);
      repeat (3) cyc(1, 0, '0);
      repeat (2) cyc(0, 0, '0);
      cyc(1, 1, 30'h100);
      cyc(1, 0, '0);
      cyc(1, 0, '0);
      chk("full_redir_pc", fetch_pc, 30'h100);
      repeat (3000) cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 30'($urandom));
      repeat (4) cyc(1, 0, '0);
      @(posedge clk);
      #2;
      chk("pre_rst_valid", 64'(fetch_valid), 64'(1));
      rst = 0;
      #1;
      chk("arst_valid", 64'(fetch_valid), 64'(0));
      chk("arst_addr", imem_addr, 30'h0);
      chk("arst_pc", fetch_pc, 30'h0);
      chk("arst_inst", fetch_inst, 32'h0);
      chk("arst_w_addr", w_addr, 30'h3FFF_FFFE);
`ifdef IMEM_FETCH_PERF_EN
      chk("arst_perf_stall", p_stall, 0);
      chk("arst_perf_redir", p_redir, 0);
      chk("arst_perf_fetch", p_fetch, 0);
`endif
      repeat (2) @(posedge clk);
      release_rst();
      repeat (20) cyc(1, 0, '0);
      repeat (300) cyc($urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, 30'($urandom));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
